// File: rtl/exp1_pkg.sv
// Shared definitions for the exp1 stimulus/response tester.
// Holds the FSM state encoding, vector count, golden truth table for
// Z = A & (B | C), and the register widths used by the tester and its
// settle timer.
package exp1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int ERR_W       = 4;
    localparam int CNT_W       = 8;

    // Bit i is the expected Z for input vector {A,B,C} = i.
    localparam logic [NUM_VECTORS-1:0] EXPECTED_MASK = 8'hE0;

    function automatic logic golden(input logic [IDX_W-1:0] idx);
        return EXPECTED_MASK[idx];
    endfunction

endpackage

// File: rtl/exp1_tester_if.sv
// Bus between the exp1 tester and the lab top level.
// Signals:
//   start     - run request (into tester)
//   z_i       - DUT output Z (into tester)
//   a_o/b_o/c_o - DUT inputs A/B/C (from tester)
//   busy, done, pass, err_count, fail_vec - status (from tester)
// Modports: master = tester side, slave = environment side.
interface exp1_tester_if;
    import exp1_pkg::*;

    logic                   start;
    logic                   z_i;
    logic                   a_o;
    logic                   b_o;
    logic                   c_o;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [ERR_W-1:0]       err_count;
    logic [NUM_VECTORS-1:0] fail_vec;

    modport master (
        input  start, z_i,
        output a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, z_i,
        input  a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/exp1_settle_timer.sv
// Settle down-counter for the exp1 tester.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_load         - load i_load_value into the counter this edge
//   i_load_value   - value loaded (number of settle cycles minus one)
//   o_zero         - counter has reached zero
// The counter stops at zero until reloaded.
module exp1_settle_timer
    import exp1_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/exp1_tester.sv
// Stimulus/response tester for the A & (B | C) function block.
// Steps {A,B,C} through 0..7, holds each vector SETTLE_CYCLES cycles,
// samples Z for one cycle and scores it against the golden table.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - exp1_tester_if master: start/z_i in; a_o/b_o/c_o,
//                busy, done, pass, err_count, fail_vec out
// Parameter SETTLE_CYCLES: hold time per vector, 1..255.
module exp1_tester
    import exp1_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    exp1_tester_if.master bus
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [IDX_W-1:0]       r_idx;
    logic [ERR_W-1:0]       r_err_count;
    logic [NUM_VECTORS-1:0] r_fail_vec;

    logic w_start_run;
    logic w_check;
    logic w_advance;
    logic w_load;
    logic w_zero;
    logic w_mismatch;

    exp1_settle_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_value (LOAD_VAL),
        .o_zero       (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start_run = 1'b0;
        w_check     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            // start is only honoured when no run is in progress
            IDLE, DONE: begin
                if (bus.start) begin
                    w_start_run = 1'b1;
                    w_next      = SETTLE;
                end
            end
            SETTLE: begin
                if (w_zero) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_check = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_next = DONE;
                end else begin
                    w_advance = 1'b1;
                    w_next    = SETTLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_load     = w_start_run | w_advance;
    // z_i is only looked at during the single CHECK cycle
    assign w_mismatch = w_check && (bus.z_i != golden(r_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_err_count <= '0;
            r_fail_vec  <= '0;
        end else if (w_start_run) begin
            r_idx       <= '0;
            r_err_count <= '0;
            r_fail_vec  <= '0;
        end else begin
            if (w_mismatch) begin
                r_err_count        <= r_err_count + 1'b1;
                r_fail_vec[r_idx]  <= 1'b1;
            end
            // idx stops at 7 on the last CHECK, so it never wraps mid-run
            if (w_advance) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // DUT inputs come straight from the idx flops so they never glitch
    assign bus.a_o       = r_idx[2];
    assign bus.b_o       = r_idx[1];
    assign bus.c_o       = r_idx[0];
    assign bus.busy      = (r_state == SETTLE) || (r_state == CHECK);
    assign bus.done      = (r_state == DONE);
    assign bus.pass      = (r_state == DONE) && (r_err_count == '0);
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_exp1_tester.sv
// Directed bench for exp1_tester: runs it against correct and faulty
// models of the A & (B | C) block, a mid-run reset, and a back-to-back
// rerun configuration with SETTLE_CYCLES=1.
module tb_exp1_tester;

    logic clk;
    logic rst_n;
    int   mode;        // 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 z=a
    logic dut_z;
    int   n_checks;
    int   n_errors;

    exp1_tester_if bus ();
    exp1_tester_if bus2 ();

    exp1_tester #(.SETTLE_CYCLES(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp1_tester #(.SETTLE_CYCLES(1)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dut_z = 1'b0;
        case (mode)
            0: dut_z = bus.a_o & (bus.b_o | bus.c_o);
            1: dut_z = 1'b0;
            2: dut_z = 1'b1;
            3: dut_z = bus.a_o;
            default: dut_z = 1'b0;
        endcase
    end

    assign bus.z_i  = dut_z;
    assign bus2.z_i = bus2.a_o & (bus2.b_o | bus2.c_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs1();
        return 32'({bus.a_o, bus.b_o, bus.c_o, bus.busy, bus.done, bus.pass,
                    bus.err_count, bus.fail_vec});
    endfunction

    // Pulse start, then follow a full SETTLE_CYCLES=4 run to DONE.
    task automatic run_vectors(input string tag, input logic [3:0] e_err, input logic [7:0] e_fv);
        int busy_cyc;
        int seq_bad;
        busy_cyc = 0;
        seq_bad  = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_startdone"}, 32'({bus.done, bus.busy}), 32'h1);
        for (int k = 0; k < 40; k++) begin
            if (bus.busy) busy_cyc++;
            if ({bus.a_o, bus.b_o, bus.c_o} != 3'(k / 5)) seq_bad++;
            if (bus.done) seq_bad++;
            @(negedge clk);
        end
        chk({tag, "_busycyc"}, 32'(busy_cyc), 32'd40);
        chk({tag, "_seq"}, 32'(seq_bad), 32'd0);
        chk({tag, "_done"}, 32'({bus.done, bus.busy}), 32'h2);
        chk({tag, "_pass"}, 32'(bus.pass), 32'(e_err == 4'd0));
        chk({tag, "_err"}, 32'(bus.err_count), 32'(e_err));
        chk({tag, "_fv"}, 32'(bus.fail_vec), 32'(e_fv));
        chk({tag, "_abc"}, 32'({bus.a_o, bus.b_o, bus.c_o}), 32'h7);
    endtask

    initial begin
        int first_done;
        int second_done;
        int done_cnt;
        int busy2;
        int seq2_bad;
        logic pass16;

        n_checks   = 0;
        n_errors   = 0;
        mode       = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus2.start = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs1(), 32'h0);
        chk("reset_outs2", 32'({bus2.a_o, bus2.b_o, bus2.c_o, bus2.busy, bus2.done,
                                bus2.pass, bus2.err_count, bus2.fail_vec}), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", all_outs1(), 32'h0);

        mode = 0;
        run_vectors("good", 4'd0, 8'h00);
        mode = 1;
        run_vectors("sa0", 4'd3, 8'hE0);
        mode = 2;
        run_vectors("sa1", 4'd5, 8'h1F);
        mode = 3;
        run_vectors("z_a", 4'd1, 8'h10);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'({bus.done, bus.err_count, bus.fail_vec}), 32'h1110);
        mode = 0;
        run_vectors("restart", 4'd0, 8'h00);

        // start while busy is ignored, then an asynchronous abort
        mode = 2;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("midstart_abc", 32'({bus.a_o, bus.b_o, bus.c_o}), 32'h2);
        chk("midstart_busy", 32'({bus.busy, bus.done}), 32'h2);
        repeat (9) @(negedge clk);
        chk("partial_err", 32'(bus.err_count), 32'd3);
        chk("partial_fv", 32'(bus.fail_vec), 32'h07);
        rst_n = 1'b0;
        #1;
        chk("abort_async", all_outs1(), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle", all_outs1(), 32'h0);
        mode = 0;
        run_vectors("after_rst", 4'd0, 8'h00);

        // SETTLE_CYCLES=1 with start held: runs of 16 cycles back-to-back
        first_done  = -1;
        second_done = -1;
        done_cnt    = 0;
        busy2       = 0;
        seq2_bad    = 0;
        pass16      = 1'b0;
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 35; k++) begin
            if (bus2.done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
            if (k < 16) begin
                if (bus2.busy) busy2++;
                if ({bus2.a_o, bus2.b_o, bus2.c_o} != 3'(k / 2)) seq2_bad++;
            end
            if (k == 16) pass16 = bus2.pass;
            if (k == 17) chk("s1_rerun", 32'({bus2.busy, bus2.done, bus2.a_o, bus2.b_o, bus2.c_o}), 32'h10);
            @(negedge clk);
        end
        bus2.start = 1'b0;
        chk("s1_busy", 32'(busy2), 32'd16);
        chk("s1_seq", 32'(seq2_bad), 32'd0);
        chk("s1_first_done", 32'(first_done), 32'd16);
        chk("s1_second_done", 32'(second_done), 32'd33);
        chk("s1_done_cnt", 32'(done_cnt), 32'd2);
        chk("s1_pass", 32'(pass16), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
